// File: rtl/gf_pkg.sv
// gf_pkg: GF(151) constants, element/product types and exponentiation FSM states shared by gf_pow_engine and gf_mul_red
package gf_pkg;
  localparam int P = 151;
  localparam int MU = 434;
  localparam int K = 8;
  localparam int EXP_W = 8;
  localparam int IDX_W = $clog2(EXP_W);
  typedef logic [K-1:0] elem_t;
  typedef logic [2*K-2:0] prod_t;
  typedef logic [EXP_W-1:0] exp_t;
  typedef logic [IDX_W-1:0] idx_t;
  localparam elem_t P_E = elem_t'(P);
  localparam logic [15:0] P16 = 16'(P);
  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;
endpackage

// File: rtl/gf_mul_red.sv
// gf_mul_red: combinational a*b mod P via Barrett reduction; ports a,b (elements < P) in, r (< P) out
module gf_mul_red
  import gf_pkg::*;
(
  input  elem_t a,
  input  elem_t b,
  output elem_t r
);
  prod_t x;
  logic [15:0] m, tp, r0, r1, r2;
  logic [K-1:0] t;
  always_comb begin
    x = prod_t'(a) * prod_t'(b);
    m = 16'(x[2*K-2:K]) * 16'(MU);
    t = m[15:K];
    tp = 16'(t) * P16;
    r0 = 16'(x) - tp;
    r1 = r0 >= P16 ? r0 - P16 : r0;
    r2 = r1 >= P16 ? r1 - P16 : r1;
    r = r2[K-1:0];
  end
endmodule

// File: rtl/gf_pow_engine.sv
// gf_pow_engine: base^exp mod P by MSB-first square-and-multiply; in (in_valid/in_ready, in_base, in_exp, in_inv when GF_POW_INV_EN) -> out (out_valid/out_ready, out_res)
module gf_pow_engine
  import gf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_base,
  input  logic [EXP_W-1:0] in_exp,
`ifdef GF_POW_INV_EN
  input  logic             in_inv,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_res
);
  state_t state, state_n;
  elem_t base_q, acc, rr;
  exp_t exp_q, exp_in;
  idx_t idx;
  logic accept;
`ifdef GF_POW_INV_EN
  assign exp_in = in_inv ? exp_t'(P - 2) : in_exp;
`else
  assign exp_in = in_exp;
`endif
  gf_mul_red u_mul_red (.a(acc), .b(state == SQR ? acc : base_q), .r(rr));
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    out_res = out_valid ? acc : '0;
    accept = in_valid && in_ready;
    state_n = state == IDLE ? (accept ? SQR : IDLE) :
              state == SQR  ? MUL :
              state == MUL  ? (idx == '0 ? DONE : SQR) :
                              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      base_q <= '0;
      exp_q <= '0;
      acc <= elem_t'(1);
      idx <= idx_t'(EXP_W - 1);
    end else if (accept) begin
      base_q <= in_base >= P_E ? in_base - P_E : in_base;
      exp_q <= exp_in;
      acc <= elem_t'(1);
      idx <= idx_t'(EXP_W - 1);
    end else if (state == SQR) acc <= rr;
    else if (state == MUL) begin
      if (exp_q[idx]) acc <= rr;
      if (idx != '0) idx <= idx - 1'b1;
    end
endmodule

// File: tb/tb_gf_pow_engine.sv
// tb_gf_pow_engine: randomized and directed self-check of gf_pow_engine against a repeated-multiplication model
module tb_gf_pow_engine;
  localparam int P = 151;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, in_inv = 0;
  logic in_ready, out_valid;
  logic [7:0] in_base = 0, in_exp = 0, out_res;
  int checks = 0, failures = 0;
  gf_pow_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_base(in_base), .in_exp(in_exp),
`ifdef GF_POW_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  function automatic int model(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * (b % P)) % P;
    return r;
  endfunction
  task automatic job(input string tag, input int b, input int e, input bit inv, input int hold, input int want);
    int lat = 0;
    @(negedge clk);
    in_valid = 1; in_base = 8'(b); in_exp = 8'(e); in_inv = inv;
    @(posedge clk); #1;
    in_valid = 0; in_base = 8'($urandom); in_exp = 8'($urandom); in_inv = 0;
    chk({tag, "_busy"}, 32'(in_ready), 0);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 16);
    chk({tag, "_res"}, 32'(out_res), want);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {30'(out_res), out_valid, in_ready}, {30'(want), 1'b1, 1'b0});
    end
    @(negedge clk); out_ready = 1;
    @(posedge clk); #1; out_ready = 0;
    chk({tag, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask
  initial begin
    #12;
    chk("reset", {22'(out_res), out_valid, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1;
    job("b3e5", 3, 5, 0, 0, 92);
    job("b2e8", 2, 8, 0, 1, 105);
    job("b200e1", 200, 1, 0, 0, 49);
    job("b0e0", 0, 0, 0, 0, 1);
    job("b0e7", 0, 7, 0, 0, 0);
    job("b150e2", 150, 2, 0, 0, 1);
    job("b151e3", 151, 3, 0, 0, 0);
    job("b255e1", 255, 1, 0, 0, 104);
    job("bp", 7, 13, 0, 10, model(7, 13));
    @(negedge clk);
    in_valid = 1; in_base = 8'd5; in_exp = 8'd200;
    @(posedge clk); #1; in_valid = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 0;
    #1 chk("rst_mid", {30'd0, out_valid, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1;
    job("after_rst", 5, 200, 0, 0, model(5, 200));
    for (int n = 0; n < 20; n++) begin
      int b = int'($urandom_range(0, 255));
      int e = int'($urandom_range(0, 255));
      job("rand", b, e, 0, int'($urandom_range(0, 3)), model(b, e));
    end
`ifdef GF_POW_INV_EN
    job("inv2", 2, 9, 1, 0, 76);
    job("inv0", 0, 3, 1, 0, 0);
    for (int n = 0; n < 5; n++) begin
      int b = int'($urandom_range(1, 150));
      int r = model(b, P - 2);
      chk("inv_prod", (b * r) % P, 1);
      job("inv_rand", b, int'($urandom_range(0, 255)), 1, 0, r);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
